// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer pipeline stages.
// Latency: none; this package holds only types, constants and functions.
// Backpressure: none.
package fc_pkg;

    // Sequencer phases. The ST_ prefix keeps the names distinct from the
    // SETTLE parameter of the sequencer.
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Default layer geometry shared by neighbouring stages.
    localparam int FC_WIDTH = 8;
    localparam int FC_IN    = 128;
    localparam int ZW       = FC_WIDTH * 2 + $clog2(FC_IN);
    localparam int IDX_W    = $clog2(FC_IN);

    // Pointer width for an n-entry index that never collapses to 0 bits.
    function automatic int fc_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_act_bank.sv
// IN x WIDTH activation register file with one write port, tail zero-fill and full parallel read.
// Latency: a write or zero-fill is visible on rdata one cycle after it is requested.
// Backpressure: none; the bank takes every command issued in a cycle.
module fc_act_bank #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [fc_pkg::fc_ptr_w(IN)-1:0] widx,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         zfill,
    output logic [IN-1:0][WIDTH-1:0]     rdata
);
    import fc_pkg::*;

    localparam int IW = fc_ptr_w(IN);

    logic [IN-1:0][WIDTH-1:0] mem_q;
    logic [IN-1:0][WIDTH-1:0] mem_d;

    // Zero-fill clears every entry above widx. A write at widx in the same
    // cycle takes precedence over the clear.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < IN; i++) begin
            if (zfill && (IW'(i) > widx)) begin
                mem_d[i] = '0;
            end
            if (we && (IW'(i) == widx)) begin
                mem_d[i] = wdata;
            end
        end
    end

    // Entry storage; reset clears the whole bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q;

endmodule

// File: rtl/fc_input_sequencer.sv
// Deserialises an activation stream into x, holds x for SETTLE cycles, then registers the layer result z.
// Latency: last beat accepted in cycle t gives r_valid in cycle t+SETTLE+1.
// Backpressure: s_ready is decoded from registered state only; r_valid/r_data hold until r_ready.
// Build option FC_SEQ_DOUBLE_BUF_EN adds a second bank so the next frame can
// fill while the current one settles or waits for the result to be accepted.
module fc_input_sequencer #(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int SETTLE = 2,
    parameter int ZW     = WIDTH * 2 + $clog2(IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_last,
    output logic [IN-1:0][WIDTH-1:0] x,
    input  logic [ZW-1:0]            z,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [ZW-1:0]            r_data,
    output logic                     frame_err
);
    import fc_pkg::*;

    localparam int             IW        = fc_ptr_w(IN);
    localparam int             CW        = fc_ptr_w(SETTLE);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(IN - 1);
    localparam logic [CW-1:0]  CNT_INIT  = CW'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            r_valid_q, r_valid_d;
    logic [ZW-1:0]   r_data_q, r_data_d;
    logic            frame_err_q, frame_err_d;

    logic            accept;
    logic            idx_max;
    logic            frame_end;
    logic            frame_short;
    logic            r_fire;
    logic            settle_done;

`ifdef FC_SEQ_DOUBLE_BUF_EN
    // act_sel: bank shown on x. done: the background bank holds a complete
    // frame that is waiting for the current result to be accepted.
    logic            act_sel_q, act_sel_d;
    logic            done_q, done_d;
    logic            fill_sel;
    logic [1:0]      bank_we;
    logic [1:0]      bank_zf;
    logic [IN-1:0][WIDTH-1:0] bank_rd [2];
`else
    logic            bank_we;
    logic            bank_zf;
    logic [IN-1:0][WIDTH-1:0] bank_rd;
`endif

    // Handshake and frame-boundary decode; s_ready depends on registered state only.
    always_comb begin
`ifdef FC_SEQ_DOUBLE_BUF_EN
        s_ready  = (state_q == ST_FILL) || !done_q;
        fill_sel = (state_q == ST_FILL) ? act_sel_q : ~act_sel_q;
`else
        s_ready  = (state_q == ST_FILL);
`endif
        accept      = s_valid && s_ready;
        idx_max     = (idx_q == IDX_LAST);
        frame_end   = accept && (idx_max || s_last);
        frame_short = accept && s_last && !idx_max;
        r_fire      = r_valid_q && r_ready;
        settle_done = (state_q == ST_SETTLE) && (cnt_q == '0);
`ifdef FC_SEQ_DOUBLE_BUF_EN
        bank_we = 2'b00;
        bank_zf = 2'b00;
        bank_we[fill_sel] = accept;
        bank_zf[fill_sel] = frame_short;
`else
        bank_we = accept;
        bank_zf = frame_short;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fill until the frame closes, settle, then offer the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (frame_end) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (r_fire) begin
`ifdef FC_SEQ_DOUBLE_BUF_EN
                    // A frame completed in the background skips FILL entirely.
                    state_d = (done_q || frame_end) ? ST_SETTLE : ST_FILL;
`else
                    state_d = ST_FILL;
`endif
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Datapath next-state: write index, settle counter, result register, error pulse.
    always_comb begin
        idx_d = idx_q;
        if (frame_end) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
        end

        cnt_d = cnt_q;
        if ((state_q != ST_SETTLE) && (state_d == ST_SETTLE)) begin
            cnt_d = CNT_INIT;
        end else if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        if (settle_done) begin
            r_valid_d = 1'b1;
            r_data_d  = z;
        end else if (r_fire) begin
            r_valid_d = 1'b0;
        end

        // Both short and over-long frames are flagged; the frame still closes.
        frame_err_d = accept && (idx_max != s_last);

`ifdef FC_SEQ_DOUBLE_BUF_EN
        done_d = done_q;
        if ((state_q != ST_FILL) && frame_end) begin
            done_d = 1'b1;
        end
        if (r_fire) begin
            done_d = 1'b0;
        end
        // After a result is accepted the background bank always becomes the
        // visible one, whether it is complete (swap into SETTLE) or partial.
        act_sel_d = r_fire ? ~act_sel_q : act_sel_q;
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            frame_err_q <= 1'b0;
`ifdef FC_SEQ_DOUBLE_BUF_EN
            act_sel_q   <= 1'b0;
            done_q      <= 1'b0;
`endif
        end else begin
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            frame_err_q <= frame_err_d;
`ifdef FC_SEQ_DOUBLE_BUF_EN
            act_sel_q   <= act_sel_d;
            done_q      <= done_d;
`endif
        end
    end

`ifdef FC_SEQ_DOUBLE_BUF_EN
    for (genvar b = 0; b < 2; b++) begin : g_bank
        fc_act_bank #(
            .WIDTH (WIDTH),
            .IN    (IN)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[b]),
            .widx  (idx_q),
            .wdata (s_data),
            .zfill (bank_zf[b]),
            .rdata (bank_rd[b])
        );
    end

    assign x = act_sel_q ? bank_rd[1] : bank_rd[0];
`else
    fc_act_bank #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .widx  (idx_q),
        .wdata (s_data),
        .zfill (bank_zf),
        .rdata (bank_rd)
    );

    assign x = bank_rd;
`endif

    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fc_input_sequencer.sv
// Randomised scoreboard bench for fc_input_sequencer with a sum-of-activations layer model.
// Latency: checks r_valid arrives SETTLE+1 cycles after the closing beat (single-bank build).
// Backpressure: drives random r_ready stalls and long holds on the result port.
module tb_fc_input_sequencer;
    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int SETTLE = 2;
    localparam int ZW     = WIDTH * 2 + $clog2(IN);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     s_valid;
    logic                     s_ready;
    logic [WIDTH-1:0]         s_data;
    logic                     s_last;
    logic [IN-1:0][WIDTH-1:0] x;
    logic [ZW-1:0]            z;
    logic                     r_valid;
    logic                     r_ready;
    logic [ZW-1:0]            r_data;
    logic                     frame_err;

    fc_input_sequencer #(
        .WIDTH(WIDTH), .IN(IN), .SETTLE(SETTLE), .ZW(ZW)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .x(x), .z(z),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Combinational layer: plain sum of the presented activations.
    always_comb begin
        z = '0;
        for (int i = 0; i < IN; i++) z = z + ZW'(x[i]);
    end

    typedef struct {
        logic [ZW-1:0]            sum;
        bit                       err;
        int                       t_last;
        logic [IN-1:0][WIDTH-1:0] vec;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rr_mode = 1;   // 0: hold low, 1: hold high, 2: random

    // Reference model state: position within the open frame and its contents.
    int                       m_idx = 0;
    logic [IN-1:0][WIDTH-1:0] m_vec = '0;
    logic [ZW-1:0]            m_sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [IN-1:0][WIDTH-1:0] act,
                           input logic [IN-1:0][WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            int k;
            k = 0;
            for (int i = IN - 1; i >= 0; i--) if (act[i] !== exp[i]) k = i;
            n_bad++;
            $display("FAIL %s: x[%0d] got %0d expected %0d (cycle %0d)", nm, k, act[k], exp[k], cyc);
        end
    endtask

    // Model: a frame closes on s_last or on its IN-th beat; anything else is an error.
    task automatic model_beat(input logic [WIDTH-1:0] d, input bit last, input int t);
        exp_t e;
        m_vec[m_idx] = d;
        m_sum = m_sum + ZW'(d);
        if (last || m_idx == IN - 1) begin
            e.sum    = m_sum;
            e.err    = !(last && m_idx == IN - 1);
            e.t_last = t;
            e.vec    = m_vec;
            exp_q.push_back(e);
            m_vec = '0;
            m_sum = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Precondition and postcondition: called and returning just after a negedge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last);
        bit acc;
        int t;
        int waitc;
        waitc = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            acc = s_ready;
            t   = cyc;
            @(posedge clk);
            if (acc) begin
                model_beat(d, last, t);
                break;
            end
            waitc++;
            if (waitc > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_timeout: s_ready stayed %0d, required 1", s_ready);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || r_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending %0d results, required 0", exp_q.size());
        end
    endtask

    // Result-port driver, updated just after each rising edge.
    initial begin
        r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       r_ready = 1'b0;
                1:       r_ready = 1'b1;
                default: r_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each new result and checks protocol every cycle.
    initial begin
        bit            prev_valid;
        bit            acc_prev;
        bit            err_seen;
        logic [ZW-1:0] prev_data;
        exp_t          cur;
        prev_valid = 0;
        acc_prev   = 0;
        err_seen   = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 0;
                acc_prev   = 0;
                err_seen   = 0;
            end else begin
                if (frame_err) err_seen = 1;
`ifndef FC_SEQ_DOUBLE_BUF_EN
                if (acc_prev) begin
                    chk("s_ready_after_accept", s_ready, 1);
                    chk("r_valid_after_accept", r_valid, 0);
                end
                if (r_valid) chk("s_ready_in_out", s_ready, 0);
`endif
                if (r_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: r_data %0d with empty scoreboard", r_data);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("r_data", r_data, cur.sum);
                        chk_vec("x_frozen", x, cur.vec);
`ifndef FC_SEQ_DOUBLE_BUF_EN
                        chk("latency", cyc - cur.t_last, SETTLE + 1);
                        chk("frame_err", err_seen, cur.err);
`endif
                        err_seen = 0;
                    end
                end else if (r_valid && prev_valid) begin
                    chk("r_data_stable", r_data, prev_data);
                end
                acc_prev   = r_valid && r_ready;
                prev_valid = r_valid;
                prev_data  = r_data;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] v128;
        logic [WIDTH-1:0] v129;
        int len;
        bit last;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        rr_mode = 1;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", s_ready, 1);
        chk("reset_r_valid", r_valid, 0);
        chk("reset_r_data", r_data, 0);
        chk("reset_frame_err", frame_err, 0);
        chk_vec("reset_x", x, '0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp frame, sum 8128.
        for (int i = 0; i < IN; i++) send_beat(WIDTH'(i & 8'hFF), i == IN - 1);
        wait_drain();

        // Short frame: ten ones, tail must read zero.
        for (int i = 0; i < 10; i++) send_beat(WIDTH'(1), i == 9);
        wait_drain();

        // Over-long frame: beats 128 and 129 open the next frame.
        for (int i = 0; i < 130; i++) begin
            v = WIDTH'($urandom);
            if (i == 128) v128 = v;
            if (i == 129) v129 = v;
            send_beat(v, 1'b0);
        end
`ifndef FC_SEQ_DOUBLE_BUF_EN
        chk("long_carry_x0", x[0], v128);
        chk("long_carry_x1", x[1], v129);
`endif
        for (int i = 2; i < 10; i++) send_beat(WIDTH'($urandom), i == 9);
        wait_drain();

        // Result held back for 20 cycles.
        rr_mode = 0;
        for (int i = 0; i < IN; i++) send_beat(WIDTH'($urandom), i == IN - 1);
        for (int n = 0; n < 100 && !r_valid; n++) @(negedge clk);
        chk("hold_r_valid", r_valid, 1);
        repeat (20) @(negedge clk);
        rr_mode = 1;
        wait_drain();

        // Reset in the middle of a frame.
        for (int i = 0; i < 64; i++) send_beat(WIDTH'($urandom), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0;
        m_vec = '0;
        m_sum = '0;
        chk_vec("midreset_x", x, '0);
        chk("midreset_r_valid", r_valid, 0);
        chk("midreset_s_ready", s_ready, 1);
        for (int i = 0; i < IN; i++) send_beat(WIDTH'($urandom), i == IN - 1);
        wait_drain();

        // Back-to-back full frames with the result port always ready.
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < IN; i++) send_beat(WIDTH'($urandom), i == IN - 1);
        wait_drain();

        // Random frame lengths, idle gaps and result stalls.
        rr_mode = 2;
        for (int f = 0; f < 14; f++) begin
            len = $urandom_range(1, IN + 4);
            last = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send_beat(WIDTH'($urandom), last && (i == len - 1));
            end
        end
        send_beat(WIDTH'($urandom), 1'b1);
        wait_drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
